// File: rtl/line_buffer_reader.sv
// Streaming line-buffer read controller: walks a circular line in BRAM and presents pixels as a valid/ready stream.
// Optional build macro LINE_BUFFER_READER_CHECK_EN adds o_err and rejects out-of-range starts.
module line_buffer_reader #(
  parameter int DEPTH  = 2000,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_length,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_done
`ifdef LINE_BUFFER_READER_CHECK_EN
  ,
  output logic              o_err
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_issue_left;
  logic              r_flag0;
  logic              r_flag1;
  logic              r_last0;
  logic              r_last1;
  logic              r_done;

  logic [DATA_W-1:0] r_fifo_data [4];
  logic              r_fifo_last [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;

  logic              w_start_bad;
  logic              w_accept;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic              w_finish;
  logic [2:0]        w_occupancy;
  logic [ADDR_W-1:0] w_next_addr;

`ifdef LINE_BUFFER_READER_CHECK_EN
  logic              r_err;
  assign w_start_bad = (i_length > L_DEPTH) || (i_base_addr >= L_DEPTH);
  assign o_err       = r_err;
`else
  assign w_start_bad = 1'b0;
`endif

  // Reads in flight plus buffered pixels never exceed the FIFO depth, so a push always has room.
  assign w_occupancy = r_count + {2'b00, r_flag0} + {2'b00, r_flag1};
  assign w_issue     = (r_state == READ) && (r_issue_left != '0) && (w_occupancy < 3'd4);
  assign w_push      = r_flag1;
  assign w_pop       = o_m_valid && i_m_ready;
  assign w_drained   = (r_count == 3'd0) && !r_flag0 && !r_flag1;
  assign w_next_addr = (r_rd_addr >= L_LAST) ? '0 : r_rd_addr + L_ONE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start && !w_start_bad && (i_length != '0)) w_next_state = READ;
      READ:    if ((r_issue_left == '0) || (w_issue && (r_issue_left == L_ONE))) w_next_state = DRAIN;
      DRAIN:   if (w_drained) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (r_state != IDLE);
    w_accept = (r_state == IDLE) && i_start && !w_start_bad;
    w_finish = (r_state == DRAIN) && w_drained;
  end

  // The accepting edge itself issues the first read by loading base into the address register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_addr    <= '0;
      r_issue_left <= '0;
      r_flag0      <= 1'b0;
      r_flag1      <= 1'b0;
      r_last0      <= 1'b0;
      r_last1      <= 1'b0;
      r_done       <= 1'b0;
`ifdef LINE_BUFFER_READER_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_done  <= w_finish || (w_accept && (i_length == '0));
      r_flag1 <= r_flag0;
      r_last1 <= r_last0;
`ifdef LINE_BUFFER_READER_CHECK_EN
      r_err   <= (r_state == IDLE) && i_start && w_start_bad;
`endif
      if (w_accept && (i_length != '0)) begin
        r_rd_addr    <= i_base_addr;
        r_issue_left <= i_length - L_ONE;
        r_flag0      <= 1'b1;
        r_last0      <= (i_length == L_ONE);
      end else if (w_issue) begin
        r_rd_addr    <= w_next_addr;
        r_issue_left <= r_issue_left - L_ONE;
        r_flag0      <= 1'b1;
        r_last0      <= (r_issue_left == L_ONE);
      end else begin
        r_flag0      <= 1'b0;
        r_last0      <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= i_rd_data;
        r_fifo_last[r_wr_ptr] <= r_last1;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // First-word-fall-through: the head entry drives the stream directly and only moves on a handshake.
  assign o_m_valid = (r_count != 3'd0);
  assign o_m_data  = r_fifo_data[r_rd_ptr];
  assign o_m_last  = o_m_valid && r_fifo_last[r_rd_ptr];
  assign o_rd_addr = r_rd_addr;
  assign o_done    = r_done;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Self-checking bench for line_buffer_reader: BRAM model, queue-based pixel reference, directed and random lines.
// Exercises o_err only when LINE_BUFFER_READER_CHECK_EN is defined.
module tb_line_buffer_reader;

  localparam int DEPTH  = 2000;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] lengthIn;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] mData;
  logic              mValid;
  logic              mReady;
  logic              mLast;
  logic              busy;
  logic              done;
`ifdef LINE_BUFFER_READER_CHECK_EN
  logic              err;
`endif

  logic [DATA_W-1:0] refMem [DEPTH];
  int assertCount = 0;
  int failCount   = 0;

  line_buffer_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (baseAddr),
    .i_length    (lengthIn),
    .o_rd_addr   (rdAddr),
    .i_rd_data   (rdData),
    .o_m_data    (mData),
    .o_m_valid   (mValid),
    .i_m_ready   (mReady),
    .o_m_last    (mLast),
    .o_busy      (busy),
    .o_done      (done)
`ifdef LINE_BUFFER_READER_CHECK_EN
    ,
    .o_err       (err)
`endif
  );

  always #5 clk = ~clk;

  // BRAM read port: one-cycle registered output.
  always @(posedge clk) rdData <= refMem[int'(rdAddr) % DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one line; readyMode 0 = always ready, 1 = alternating 1,0,..., 2 = random.
  task automatic applyStimulus(input int base, input int len, input int readyMode, input bit pokeStart);
    int          expQ[$];
    int          cyc;
    int          lastHs;
    int          hsCount;
    int          limit;
    int          expPix;
    logic        prevStall;
    logic [7:0]  prevData;
    logic        prevLast;
    for (int i = 0; i < len; i++) expQ.push_back(int'(refMem[(base + i) % DEPTH]));
    cyc       = 0;
    hsCount   = 0;
    lastHs    = (len == 0) ? -1 : (1 << 20);
    limit     = 50 + 4 * len;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    baseAddr = ADDR_W'(base);
    lengthIn = ADDR_W'(len);
    mReady   = 1'b1;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        checkOutput("busy_after_start", busy, (len != 0));
        if (len != 0) checkOutput("rd_addr_base", rdAddr, base);
      end
      if (pokeStart && cyc == 2) begin
        start    = 1'b1;
        baseAddr = ADDR_W'($urandom_range(0, DEPTH - 1));
        lengthIn = ADDR_W'($urandom_range(1, 50));
      end
      if (pokeStart && cyc == 3) start = 1'b0;
      case (readyMode)
        0:       mReady = 1'b1;
        1:       mReady = (cyc % 2 == 1);
        default: mReady = ($urandom_range(0, 3) != 0);
      endcase
      if (prevStall) begin
        checkOutput("stall_valid", mValid, 1);
        checkOutput("stall_data", mData, prevData);
        checkOutput("stall_last", mLast, prevLast);
      end
      if (readyMode == 0 && len > 0 && cyc <= len) checkOutput("rd_addr_seq", rdAddr, (base + cyc - 1) % DEPTH);
      if (len > 0 && cyc <= 2) checkOutput("early_valid", mValid, 0);
      if (len > 0 && cyc == 3) checkOutput("first_valid", mValid, 1);
      if (readyMode == 0 && len > 0 && cyc >= 3 && cyc < 3 + len) checkOutput("throughput_valid", mValid, 1);
      checkOutput("done_timing", done, (cyc == lastHs + 2));
      if (cyc == lastHs + 2) checkOutput("busy_after_done", busy, 0);
      if (len > 0 && cyc == lastHs + 1) checkOutput("busy_before_done", busy, 1);
      if (expQ.size() == 0) checkOutput("no_extra_valid", mValid, 0);
      else if (mValid && mReady) begin
        expPix = expQ.pop_front();
        checkOutput("pixel_data", mData, expPix);
        checkOutput("pixel_last", mLast, (expQ.size() == 0));
        hsCount++;
        if (expQ.size() == 0) lastHs = cyc;
      end
      prevStall = mValid && !mReady;
      prevData  = mData;
      prevLast  = mLast;
      if (cyc == lastHs + 3) break;
    end
    checkOutput("pixel_count", hsCount, len);
    checkOutput("line_complete", cyc, lastHs + 3);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    baseAddr = '0;
    lengthIn = '0;
    mReady   = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) refMem[i] = DATA_W'(i + 16);

    repeat (2) @(negedge clk);
    checkOutput("reset_rd_addr", rdAddr, 0);
    checkOutput("reset_m_valid", mValid, 0);
    checkOutput("reset_m_data", mData, 0);
    checkOutput("reset_m_last", mLast, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic line");
    applyStimulus(0, 4, 0, 1'b0);
    $display("[TB] wrap line");
    applyStimulus(1998, 4, 0, 1'b0);
    $display("[TB] backpressure line");
    applyStimulus(37, 8, 1, 1'b0);
    $display("[TB] zero length");
    applyStimulus(500, 0, 0, 1'b0);
    $display("[TB] start while busy");
    applyStimulus(int'($urandom_range(0, DEPTH - 1)), 12, 0, 1'b1);
    $display("[TB] single pixel line");
    applyStimulus(1999, 1, 2, 1'b0);
    $display("[TB] random lines");
    for (int n = 0; n < 8; n++)
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
    $display("[TB] full-depth line");
    applyStimulus(int'($urandom_range(0, DEPTH - 1)), DEPTH, 2, 1'b0);

    $display("[TB] reset mid-line");
    @(negedge clk);
    start    = 1'b1;
    baseAddr = ADDR_W'(100);
    lengthIn = ADDR_W'(10);
    mReady   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_valid", mValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_rd_addr", rdAddr, 0);
    checkOutput("midreset_m_valid", mValid, 0);
    checkOutput("midreset_m_data", mData, 0);
    checkOutput("midreset_m_last", mLast, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("post_reset_valid", mValid, 0);
      checkOutput("post_reset_done", done, 0);
      checkOutput("post_reset_busy", busy, 0);
    end
    applyStimulus(int'($urandom_range(0, DEPTH - 1)), 6, 0, 1'b0);

`ifdef LINE_BUFFER_READER_CHECK_EN
    begin
      logic [ADDR_W-1:0] heldAddr;
      $display("[TB] out-of-range start rejection");
      @(negedge clk);
      heldAddr = rdAddr;
      start    = 1'b1;
      baseAddr = ADDR_W'(0);
      lengthIn = ADDR_W'(2001);
      @(negedge clk);
      start = 1'b0;
      checkOutput("err_pulse", err, 1);
      checkOutput("err_busy", busy, 0);
      checkOutput("err_rd_addr", rdAddr, heldAddr);
      @(negedge clk);
      checkOutput("err_clear", err, 0);
      checkOutput("err_no_done", done, 0);
      checkOutput("err_no_valid", mValid, 0);
      checkOutput("err_rd_addr_hold", rdAddr, heldAddr);
      applyStimulus(5, 3, 0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
